i_fetch_requester: RTL

//  Instruction-fetch initiator; drives the request side of the instruction memory interface.

---
 rtl/i_fetch_requester.sv | 107 ++++++++++
 1 files changed

// File: rtl/i_fetch_requester.sv
// Instruction-fetch initiator: issues word-address reads from a local PC and queues {pc, data} pairs for decode.
// Request-to-visible latency is 2 cycles; issue holds off when queued plus in-flight entries would overflow the queue.
module i_fetch_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 11,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
  parameter int QUEUE_DEPTH    = 4,
  parameter int QUEUE_PTR_BITS = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_stall,
  input  logic                    i_redirect,
  input  logic [ADDRESS_BITS-1:0] i_redirect_pc,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic [ADDRESS_BITS-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]   o_mem_in_data,
  input  logic                    i_mem_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_out_data,
  output logic                    o_inst_valid,
  output logic [DATA_WIDTH-1:0]   o_inst_data,
  output logic [ADDRESS_BITS-1:0] o_inst_pc,
  input  logic                    i_inst_ready
);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  localparam logic [QUEUE_PTR_BITS:0] DEPTH_L = (QUEUE_PTR_BITS+1)'(QUEUE_DEPTH);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDRESS_BITS-1:0]   r_pc;
  logic [ADDRESS_BITS-1:0]   r_req_pc;
  logic                      r_inflight;
  logic [QUEUE_PTR_BITS:0]   r_count;
  logic [QUEUE_PTR_BITS-1:0] r_rd_ptr;
  logic [QUEUE_PTR_BITS-1:0] r_wr_ptr;
  logic [DATA_WIDTH-1:0]     r_q_data [QUEUE_DEPTH];
  logic [ADDRESS_BITS-1:0]   r_q_pc   [QUEUE_DEPTH];

  logic                      w_issue;
  logic                      w_push;
  logic                      w_pop;
  logic [QUEUE_PTR_BITS:0]   w_occupancy;

  // The in-flight response already owns a slot; a pop this cycle does not free one.
  assign w_occupancy = r_count + {{QUEUE_PTR_BITS{1'b0}}, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_issue = !i_stall && !i_redirect && (w_occupancy < DEPTH_L);
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  assign w_push = i_mem_valid && !i_redirect;
  assign w_pop  = o_inst_valid && i_inst_ready && !i_redirect;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= r_pc;
      if (i_redirect) begin
        r_pc     <= i_redirect_pc;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_issue) r_pc <= r_pc + 1'b1;
        if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= i_mem_out_data;
      r_q_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

  assign o_mem_read    = w_issue;
  assign o_mem_write   = 1'b0;
  assign o_mem_address = r_pc;
  assign o_mem_in_data = '0;
  assign o_inst_valid  = (r_count != '0);
  assign o_inst_data   = o_inst_valid ? r_q_data[r_rd_ptr] : '0;
  assign o_inst_pc     = o_inst_valid ? r_q_pc[r_rd_ptr]   : '0;

endmodule
